// File: rtl/sm83_reg_sp.sv
// sm83_reg_sp: multi-byte SM83 stack pointer with byte-serial bus load/readout,
// increment/decrement and signed-offset add (ADD SP,e / LD HL,SP+e) with H/C flags.
// A one-cycle command handshake fronts a small sequencer so the core's sequencer
// never has to track byte order on multi-beat operations.
module sm83_reg_sp #(
   parameter int               WIDTH     = 16,
   parameter int               BUS_W     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = 16'hFFFE
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [2:0]       i_cmd,
   input  logic             i_pch,
   input  logic [BUS_W-1:0] i_bus_in,
   output logic [BUS_W-1:0] o_bus_out,
   output logic             o_bus_oe,
   output logic [WIDTH-1:0] o_sp,
   output logic             o_flag_h,
   output logic             o_flag_c,
   output logic             o_done
);

   localparam int            N      = WIDTH / BUS_W;
   localparam int            KW     = $clog2(N);
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_ADD} state_t;
   // Codes 6 and 7 have no name and fall through to the NOP behaviour.
   typedef enum logic [2:0] {C_NOP, C_INC, C_DEC, C_WR, C_RD, C_ADDS} cmd_t;

   state_t           r_state, w_state_nxt;
   logic [KW-1:0]    r_k, w_k_nxt;
   logic [WIDTH-1:0] r_sp;
   logic [WIDTH-1:0] r_shadow;    // WR bytes, ADDS partial result, or RD snapshot
   logic             r_carry;     // carry between ADDS beats
   logic             r_sign;      // sign of the ADDS offset, extends the upper bytes
   logic             r_h_pend, r_c_pend;
   logic             r_flag_h, r_flag_c;
   logic             r_done;

   logic             w_accept, w_last;
   logic [BUS_W-1:0] w_sp_byte, w_sh_byte;
   logic [BUS_W-1:0] w_add_a, w_add_b;
   logic             w_add_cin, w_half;
   logic [BUS_W:0]   w_add_sum;
   logic [WIDTH-1:0] w_wr_word, w_add_word;

   assign w_accept = i_cmd_valid && (r_state == S_IDLE);
   assign w_last   = (r_k == K_LAST);

   // State register: sequencer state and beat counter.
   always_ff @(posedge i_clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples
      // pre-edge values regardless of process ordering.
      if (i_reset) begin
         r_state <= S_IDLE;
         r_k     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_k     <= w_k_nxt;
      end
   end

   // Next-state logic: multi-beat commands leave IDLE, last beat returns to it.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a variable
      // unassigned, which would infer a latch.
      w_state_nxt = r_state;
      w_k_nxt     = r_k;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (i_cmd)
                  C_WR:    begin w_state_nxt = S_WR;  w_k_nxt = KW'(1); end
                  C_RD:    begin w_state_nxt = S_RD;  w_k_nxt = '0;     end
                  C_ADDS:  begin w_state_nxt = S_ADD; w_k_nxt = KW'(1); end
                  default: ;
               endcase
            end
         end
         S_WR, S_RD, S_ADD: begin
            if (w_last) begin
               w_state_nxt = S_IDLE;
               w_k_nxt     = '0;
            end else begin
               w_k_nxt = r_k + KW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_k_nxt     = '0;
         end
      endcase
   end

   // Byte k of the committed SP and of the shadow register.
   always_comb begin
      w_sp_byte = '0;
      w_sh_byte = '0;
      for (int i = 0; i < N; i++) begin
         if (r_k == KW'(i)) begin
            w_sp_byte = r_sp[i*BUS_W +: BUS_W];
            w_sh_byte = r_shadow[i*BUS_W +: BUS_W];
         end
      end
   end

   // Byte-wide adder: low byte with the raw offset at accept, upper bytes with
   // the sign extension and the carry registered from the previous beat.
   always_comb begin
      if (r_state == S_ADD) begin
         w_add_a   = w_sp_byte;
         w_add_b   = {BUS_W{r_sign}};
         w_add_cin = r_carry;
      end else begin
         w_add_a   = r_sp[BUS_W-1:0];
         w_add_b   = i_bus_in;
         w_add_cin = 1'b0;
      end
      w_add_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{BUS_W{1'b0}}, w_add_cin};
      // Carry into bit 4 equals the carry out of bit 3.
      w_half    = w_add_a[4] ^ w_add_b[4] ^ w_add_sum[4];
   end

   // Full words committed on the last WR / ADDS beat.
   always_comb begin
      w_wr_word                      = r_shadow;
      w_wr_word[WIDTH-1 -: BUS_W]    = i_bus_in;
      w_add_word                     = r_shadow;
      w_add_word[WIDTH-1 -: BUS_W]   = w_add_sum[BUS_W-1:0];
   end

   // Datapath: SP, shadow, ADDS carry/flags and the done pulse.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sp     <= RESET_VAL;
         // NOTE: the shadow is cleared on reset so a WR cut short by reset can
         // never leak a stale byte into a later commit.
         r_shadow <= '0;
         r_carry  <= 1'b0;
         r_sign   <= 1'b0;
         r_h_pend <= 1'b0;
         r_c_pend <= 1'b0;
         r_flag_h <= 1'b0;
         r_flag_c <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  case (i_cmd)
                     C_INC: begin
                        r_sp   <= r_sp + WIDTH'(1);
                        r_done <= 1'b1;
                     end
                     C_DEC: begin
                        r_sp   <= r_sp - WIDTH'(1);
                        r_done <= 1'b1;
                     end
                     C_WR:  r_shadow[BUS_W-1:0] <= i_bus_in;
                     C_RD:  r_shadow <= r_sp;
                     C_ADDS: begin
                        r_shadow[BUS_W-1:0] <= w_add_sum[BUS_W-1:0];
                        r_carry  <= w_add_sum[BUS_W];
                        r_sign   <= i_bus_in[BUS_W-1];
                        r_h_pend <= w_half;
                        r_c_pend <= w_add_sum[BUS_W];
                     end
                     default: r_done <= 1'b1;
                  endcase
               end
            end
            S_WR: begin
               if (w_last) begin
                  r_sp   <= w_wr_word;
                  r_done <= 1'b1;
               end else begin
                  for (int i = 0; i < N; i++)
                     if (r_k == KW'(i)) r_shadow[i*BUS_W +: BUS_W] <= i_bus_in;
               end
            end
            S_ADD: begin
               if (w_last) begin
                  r_sp     <= w_add_word;
                  r_flag_h <= r_h_pend;
                  r_flag_c <= r_c_pend;
                  r_done   <= 1'b1;
               end else begin
                  for (int i = 0; i < N; i++)
                     if (r_k == KW'(i)) r_shadow[i*BUS_W +: BUS_W] <= w_add_sum[BUS_W-1:0];
                  r_carry <= w_add_sum[BUS_W];
               end
            end
            default: ;
         endcase
      end
   end

   // Bus drive: RD bytes win over precharge; nothing is driven during reset.
   always_comb begin
      o_bus_out = '0;
      o_bus_oe  = 1'b0;
      if (!i_reset) begin
         if (r_state == S_RD) begin
            o_bus_out = w_sh_byte;
            o_bus_oe  = 1'b1;
         end else if (i_pch) begin
            o_bus_out = '1;
            o_bus_oe  = 1'b1;
         end
      end
   end

   assign o_cmd_ready = (r_state == S_IDLE);
   assign o_done      = r_done | ((r_state == S_RD) && w_last);
   assign o_sp        = r_sp;
   assign o_flag_h    = r_flag_h;
   assign o_flag_c    = r_flag_c;

endmodule

// File: doc/sm83_reg_sp.md
# sm83_reg_sp

Parametrised stack-pointer register for the SM83 core: a full multi-byte SP register that generalises the single clock-enabled, precharged-bus SP bit cell. It handles byte-serial load and readout over the internal data bus, increment/decrement, and signed-offset addition (ADD SP,e / LD HL,SP+e) with H/C flag generation. A one-cycle command handshake fronts a small sequencing FSM, so the core's sequencer can issue multi-beat operations without tracking byte order itself.

## Interface
Parameters:
- WIDTH, 16: SP width in bits; must be a multiple of BUS_W.
- BUS_W, 8: data-bus width; N = WIDTH/BUS_W ≥ 2 beats per word.
- RESET_VAL, 16'hFFFE: SP value loaded by reset.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when IDLE; accept = cmd_valid & cmd_ready at an edge.
- cmd  in  3  0 NOP, 1 INC, 2 DEC, 3 WR, 4 RD, 5 ADDS; 6–7 treated as NOP.
- pch  in  1  bus precharge request.
- bus_in  in  BUS_W  byte from data bus (WR data, ADDS offset).
- bus_out  out  BUS_W  byte driven to data bus.
- bus_oe  out  1  bus_out valid/driving.
- sp  out  WIDTH  committed SP value.
- flag_h, flag_c  out  1  half-carry/carry from last ADDS.
- done  out  1  one-cycle pulse: command completed.

## Operation
- FSM states: IDLE, WR, RD, ADD; beat counter k in 0..N-1.
- NOP, INC, DEC: complete in IDLE. INC: sp+1 mod 2^WIDTH. DEC: sp−1 mod 2^WIDTH. NOP still pulses done.
- WR: byte k sampled from bus_in on beat k, low byte first, into a shadow register. sp is committed atomically on the last beat and is unchanged on intermediate beats.
- RD: snapshot of sp taken at accept. Bytes are driven low-first, one per cycle, with bus_oe=1.
- ADDS: e = bus_in at accept, sign-extended to WIDTH. One byte of sp+ext(e) is computed per beat, low byte first, with the carry registered between beats. The result and flags are committed atomically on the last beat.
  - flag_h = carry out of bit 3 of the unsigned low-byte add sp[7:0]+e.
  - flag_c = carry out of bit BUS_W−1 of the same add.
  - Flags are unchanged by all other commands.
- Precharge: in any non-RD cycle with pch=1, bus_out = all ones and bus_oe=1. RD drive wins over pch. Otherwise bus_oe=0 and bus_out=0.
- cmd_valid while busy is ignored; it is not queued.
- Reset (any cycle, including mid-command):
  - sp=RESET_VAL, state IDLE, k=0, shadow discarded.
  - flag_h=flag_c=0, done=0, bus_oe=0, bus_out=0.
  - cmd_ready=1 in the first cycle after reset deasserts.
  - Reset takes priority over an accept in the same cycle.

## Timing
- Accept at edge t.
- INC/DEC/NOP: new sp and done=1 in cycle after t; cmd_ready stays 1 (back-to-back accepted every cycle).
- WR: byte 0 sampled at edge t; byte k sampled at edge t+k.
  - New sp visible after edge t+N−1.
  - done=1 in the cycle after edge t+N−1.
  - cmd_ready=0 in cycles t+1..t+N−1.
- RD: byte k driven in the cycle after edge t+k, k=0..N−1.
  - done=1 in the byte N−1 cycle.
  - cmd_ready=0 during all N drive cycles; ready again in the following cycle.
- ADDS: sp and flags update after edge t+N−1. done and cmd_ready behave as for WR.
- A new command may be accepted in the cycle where done=1 (if cmd_ready=1).
- sp output is registered; no combinational path from cmd or bus_in to sp.

## Test plan
- Reset with cmd_valid=1, cmd=INC → after release: sp=16'hFFFE, bus_oe=0, flags 0, cmd_ready=1, no done.
- sp=16'hFFFF, INC → 16'h0000; then DEC → 16'hFFFF; back-to-back accepts with done high each cycle.
- WR with bus_in 8'h34 then 8'h12 → sp stays 16'hFFFE after beat 0 and becomes 16'h1234 after beat 1. An INC asserted mid-WR is ignored.
- ADDS cases:
  - sp=16'h00FF, e=8'h01 → sp=16'h0100, h=1, c=1.
  - sp=16'h0000, e=8'hFF → sp=16'hFFFF, h=0, c=0.
  - sp=16'h1000, e=8'h80 → sp=16'h0F80, h=0, c=0.
- sp=16'hBEEF, RD with pch=1 → bus_out 8'hEF then 8'hBE with bus_oe=1; the next cycle with pch=1 → 8'hFF, bus_oe=1; with pch=0 → bus_oe=0.
- Reset asserted after WR beat 0 → sp=16'hFFFE, IDLE. A fresh WR of 8'hCD then 8'hAB yields 16'hABCD (no stale byte).
